// File: rtl/mic_axis_pkg.sv
// Shared definitions for the microphone AXI-Stream frame path.
//   NUM_CH       channels per frame (one 32-bit word each)
//   SAMPLE_W     significant ADC sample bits per word
//   WORD_W       width of one channel word
//   BEAT_W       width of one upstream AXI-Stream beat
//   CH_PER_BEAT  channel words carried per upstream beat
//   in_state_t   input framing FSM state
//   sample_ext   turns a raw 32-bit channel word into the output word format
package mic_axis_pkg;

  localparam int NUM_CH      = 8;
  localparam int SAMPLE_W    = 24;
  localparam int WORD_W      = 32;
  localparam int BEAT_W      = 128;
  localparam int CH_PER_BEAT = 4;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } in_state_t;

  // Bits above the sample are ignored and replaced by sign or zero fill.
  function automatic logic [WORD_W-1:0] sample_ext(input logic [WORD_W-1:0] w,
                                                   input logic              sign_en);
    logic fill;
    fill = sign_en & w[SAMPLE_W-1];
    return {{(WORD_W-SAMPLE_W){fill}}, w[SAMPLE_W-1:0]};
  endfunction

endpackage

// File: rtl/mic_frame_buf.sv
// Whole-frame buffer: FRAME_DEPTH slots of NUM_CH words each.
//   sck, rst    clock, asynchronous active-high reset
//   wr_en       write one half-frame (CH_PER_BEAT words) into slot wr_ptr
//   wr_half     0 = channels 0..3, 1 = channels 4..7
//   wr_data     half-frame payload, channel i of the half at [32i+31:32i]
//   commit      publish slot wr_ptr to the reader
//   rd_ch       channel selected from slot rd_ptr
//   rd_data     selected word (undefined while empty)
//   free        release slot rd_ptr
//   count       committed, not yet freed slots
//   full, empty count flags
module mic_frame_buf
  import mic_axis_pkg::*;
#(
  parameter int FRAME_DEPTH = 2,
  localparam int PTR_W = $clog2(FRAME_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_half,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              commit,
  input  logic [2:0]        rd_ch,
  output logic [WORD_W-1:0] rd_data,
  input  logic              free,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = PTR_W + 3;

  logic [WORD_W-1:0] mem [FRAME_DEPTH*NUM_CH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage carries no reset: a slot is only readable after it has been
  // fully written and committed.
  always_ff @(posedge sck) begin
    if (wr_en) begin
      for (int i = 0; i < CH_PER_BEAT; i++) begin
        mem[ADDR_W'({wr_ptr, wr_half, i[1:0]})] <= wr_data[i*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_data = mem[ADDR_W'({rd_ptr, rd_ch})];

  // Pointers wrap naturally because FRAME_DEPTH is a power of two.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + PTR_W'(1);
      if (free)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({commit, free})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(FRAME_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mic_frame_unpacker.sv
// Unpacks two-beat 128-bit 8-channel frames into a 32-bit per-channel stream.
//   sck, rst         clock, asynchronous active-high reset
//   start            input enable; buffered frames keep draining while low
//   S_AXIS_*         128-bit upstream stream, tlast on the second beat
//   M_AXIS_tdata     sign-extended (SIGN_EXT=1) or zero-filled sample word
//   M_AXIS_tuser     channel index 0..7, M_AXIS_tlast with channel 7
//   frame_cnt        good frames committed (wrapping)
//   err_cnt          framing errors (saturating), err_sticky on any error
//
// state | meaning
// BEAT0 | waiting for the first beat (channels 0..3) of a frame
// BEAT1 | first beat stored, waiting for the closing beat (channels 4..7)
module mic_frame_unpacker
  import mic_axis_pkg::*;
#(
  parameter int FRAME_DEPTH = 2,
  parameter int SIGN_EXT    = 1
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              start,
  input  logic [BEAT_W-1:0] S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  input  logic              S_AXIS_tlast,
  output logic              S_AXIS_tready,
  output logic [WORD_W-1:0] M_AXIS_tdata,
  output logic [2:0]        M_AXIS_tuser,
  output logic              M_AXIS_tvalid,
  output logic              M_AXIS_tlast,
  input  logic              M_AXIS_tready,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt,
  output logic              err_sticky
);

  localparam int CNT_W = $clog2(FRAME_DEPTH) + 1;

  in_state_t         state_q, state_d;
  logic              ready_en_q;
  logic              beat_acc;
  logic              wr_en, wr_half, commit, frame_err;
  logic [BEAT_W-1:0] wr_data;
  logic [2:0]        ch_q;
  logic              out_hs, free;
  logic [WORD_W-1:0] rd_data;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_full, buf_empty;

  // Holds tready low for the first cycle out of reset.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  assign S_AXIS_tready = start & ready_en_q & ~buf_full;
  assign beat_acc      = S_AXIS_tvalid & S_AXIS_tready;

  always_comb begin
    for (int i = 0; i < CH_PER_BEAT; i++) begin
      wr_data[i*WORD_W +: WORD_W] = sample_ext(S_AXIS_tdata[i*WORD_W +: WORD_W],
                                               SIGN_EXT != 0);
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) state_q <= BEAT0;
    else     state_q <= state_d;
  end

  // A partial frame is dropped simply by not committing it; the next
  // frame overwrites the same slot.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_half   = 1'b0;
    commit    = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      BEAT0: begin
        if (beat_acc) begin
          if (S_AXIS_tlast) begin
            frame_err = 1'b1;
          end else begin
            wr_en   = 1'b1;
            state_d = BEAT1;
          end
        end
      end
      BEAT1: begin
        if (beat_acc) begin
          state_d = BEAT0;
          if (S_AXIS_tlast) begin
            wr_en   = 1'b1;
            wr_half = 1'b1;
            commit  = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: state_d = BEAT0;
    endcase
  end

  mic_frame_buf #(
    .FRAME_DEPTH(FRAME_DEPTH)
  ) u_buf (
    .sck    (sck),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_half(wr_half),
    .wr_data(wr_data),
    .commit (commit),
    .rd_ch  (ch_q),
    .rd_data(rd_data),
    .free   (free),
    .count  (buf_count),
    .full   (buf_full),
    .empty  (buf_empty)
  );

  // Output words come straight from the head slot; they only change on a
  // handshake, which keeps them stable under backpressure.
  assign M_AXIS_tvalid = ~buf_empty;
  assign M_AXIS_tdata  = M_AXIS_tvalid ? rd_data : '0;
  assign M_AXIS_tuser  = M_AXIS_tvalid ? ch_q : 3'd0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & (ch_q == 3'd7);
  assign out_hs        = M_AXIS_tvalid & M_AXIS_tready;
  assign free          = out_hs & (ch_q == 3'd7);

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      ch_q <= 3'd0;
    end else if (out_hs) begin
      ch_q <= ch_q + 3'd1;
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      frame_cnt  <= 16'd0;
      err_cnt    <= 8'd0;
      err_sticky <= 1'b0;
    end else begin
      if (commit) frame_cnt <= frame_cnt + 16'd1;
      if (frame_err) begin
        err_sticky <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mic_frame_unpacker.sv
module tb_mic_frame_unpacker;

  logic         sck = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] S_AXIS_tdata = '0;
  logic         S_AXIS_tvalid = 1'b0;
  logic         S_AXIS_tlast = 1'b0;
  logic         S_AXIS_tready;
  logic [31:0]  M_AXIS_tdata;
  logic [2:0]   M_AXIS_tuser;
  logic         M_AXIS_tvalid;
  logic         M_AXIS_tlast;
  logic         M_AXIS_tready = 1'b0;
  logic [15:0]  frame_cnt;
  logic [7:0]   err_cnt;
  logic         err_sticky;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;   // 0: ready high, 1: ready low, 2: random
  bit mon_en = 1'b1;
  bit stall_prev = 1'b0;
  logic [35:0] held;
  logic [35:0] exp_q[$];

  mic_frame_unpacker #(.FRAME_DEPTH(2), .SIGN_EXT(1)) dut (
    .sck(sck), .rst(rst), .start(start),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
    .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tuser(M_AXIS_tuser),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tlast(M_AXIS_tlast),
    .M_AXIS_tready(M_AXIS_tready),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 sck = ~sck;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w);
    return {{8{w[23]}}, w[23:0]};
  endfunction

  initial begin
    forever begin
      @(posedge sck);
      #1;
      case (rmode)
        0:       M_AXIS_tready = 1'b1;
        1:       M_AXIS_tready = 1'b0;
        default: M_AXIS_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected word per handshake and checks hold-under-stall.
  initial begin
    forever begin
      @(negedge sck);
      if (mon_en && !rst) begin
        if (stall_prev)
          chk("stall_hold", {3'd0, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tuser, M_AXIS_tdata},
              {4'b0001, held});
        if (M_AXIS_tvalid && M_AXIS_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word actual=%h expected=none", M_AXIS_tdata);
          end else begin
            chk("out_word", {4'd0, M_AXIS_tlast, M_AXIS_tuser, M_AXIS_tdata},
                {4'd0, exp_q.pop_front()});
          end
        end
        stall_prev = M_AXIS_tvalid && !M_AXIS_tready;
        held = {M_AXIS_tlast, M_AXIS_tuser, M_AXIS_tdata};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic l);
    int n;
    n = 0;
    @(negedge sck);
    S_AXIS_tdata = d; S_AXIS_tlast = l; S_AXIS_tvalid = 1'b1;
    while (!S_AXIS_tready && n < 400) begin
      @(negedge sck);
      n++;
    end
    if (!S_AXIS_tready) begin
      checks++; errors++;
      $display("FAIL s_tready_timeout actual=0 expected=1");
    end
    @(posedge sck);
    #1;
    S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0][31:0] fr, input bit push);
    if (push)
      for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 3'(i), ext(fr[i])});
    send_beat(fr[3:0], 1'b0);
    send_beat(fr[7:4], 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge sck);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
    end
    repeat (3) @(negedge sck);
    chk("idle_tvalid", 40'(M_AXIS_tvalid), 40'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_tready"}, 40'(S_AXIS_tready), 40'd0);
    chk({tag, "_m_tvalid"}, 40'(M_AXIS_tvalid), 40'd0);
    chk({tag, "_m_tdata"},  40'(M_AXIS_tdata),  40'd0);
    chk({tag, "_m_tuser"},  40'(M_AXIS_tuser),  40'd0);
    chk({tag, "_m_tlast"},  40'(M_AXIS_tlast),  40'd0);
    chk({tag, "_frame_cnt"}, 40'(frame_cnt), 40'd0);
    chk({tag, "_err_cnt"},  40'(err_cnt),  40'd0);
    chk({tag, "_err_sticky"}, 40'(err_sticky), 40'd0);
  endtask

  function automatic logic [7:0][31:0] mk_frame(input logic [7:0] tag);
    logic [7:0][31:0] fr;
    for (int i = 0; i < 8; i++) fr[i] = {8'hC3, tag, 4'(i), 12'h5A5 ^ {4'(i), tag}};
    return fr;
  endfunction

  logic [7:0][31:0] f1;
  logic [31:0] exp1 [8] = '{32'hFFAAAAAA, 32'hFFBBBBBB, 32'hFFCCCCCC, 32'hFFDDDDDD,
                            32'hFFEEEEEE, 32'hFFFFFFFF, 32'h00111111, 32'h00222222};
  logic [7:0][31:0] fr;

  initial begin
    start = 1'b1;
    repeat (3) @(negedge sck);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge sck);

    // Single frame, top bytes carry junk that must be discarded.
    f1 = {32'h7E222222, 32'h01111111, 32'h00FFFFFF, 32'h99EEEEEE,
          32'h12DDDDDD, 32'h00CCCCCC, 32'h44BBBBBB, 32'h12AAAAAA};
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 3'(i), exp1[i]});
    send_frame(f1, 1'b0);
    wait_drain();
    chk("frame_cnt_1", 40'(frame_cnt), 40'd1);

    // Backpressure: two frames fill the buffer, the third waits.
    rmode = 1;
    send_frame(mk_frame(8'h10), 1'b1);
    send_frame(mk_frame(8'h20), 1'b1);
    repeat (2) @(negedge sck);
    chk("full_s_tready", 40'(S_AXIS_tready), 40'd0);
    chk("full_frame_cnt", 40'(frame_cnt), 40'd3);
    fork
      send_frame(mk_frame(8'h30), 1'b1);
    join_none
    repeat (5) @(negedge sck);
    rmode = 0;
    wait_drain();
    chk("third_frame_cnt", 40'(frame_cnt), 40'd4);

    // tlast on the first beat is a framing error, next frame is clean.
    send_beat({4{32'hDEADBEEF}}, 1'b1);
    send_frame(mk_frame(8'h40), 1'b1);
    wait_drain();
    chk("beat0_err_cnt", 40'(err_cnt), 40'd1);
    chk("beat0_sticky", 40'(err_sticky), 40'd1);
    chk("beat0_frame_cnt", 40'(frame_cnt), 40'd5);

    // Two beats with tlast low: partial frame dropped, no output.
    send_beat({4{32'h00123456}}, 1'b0);
    send_beat({4{32'h00654321}}, 1'b0);
    repeat (4) @(negedge sck);
    chk("drop_tvalid", 40'(M_AXIS_tvalid), 40'd0);
    chk("drop_err_cnt", 40'(err_cnt), 40'd2);
    chk("drop_frame_cnt", 40'(frame_cnt), 40'd5);
    send_frame(mk_frame(8'h50), 1'b1);
    wait_drain();
    chk("after_drop_frame_cnt", 40'(frame_cnt), 40'd6);

    // Random downstream stalls over 20 frames.
    rmode = 2;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 8; i++) fr[i] = $urandom;
      send_frame(fr, 1'b1);
    end
    wait_drain();
    rmode = 0;
    chk("random_frame_cnt", 40'(frame_cnt), 40'd26);
    chk("random_err_cnt", 40'(err_cnt), 40'd2);

    // Reset in the middle of draining the second of two frames.
    mon_en = 1'b0;
    rmode = 1;
    send_frame(mk_frame(8'h60), 1'b0);
    send_frame(mk_frame(8'h70), 1'b0);
    rmode = 0;
    repeat (11) @(negedge sck);
    chk("mid_drain_tvalid", 40'(M_AXIS_tvalid), 40'd1);
    rst = 1'b1;
    @(negedge sck);
    check_reset_vals("mid_rst");
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (2) @(negedge sck);
    send_frame(mk_frame(8'h80), 1'b1);
    wait_drain();
    chk("post_rst_frame_cnt", 40'(frame_cnt), 40'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
